// File: rtl/nested_int_controller.sv
// Nesting interrupt controller: edge-captured sources, per-channel mask plus global enable,
// priority compare against the in-service level, and an EPC stack. Optional macro: IRQ_SYNC_EN.
module nested_int_controller #(
    parameter  int NUM_IRQ    = 8,
    parameter  int NEST_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_IRQ + 1),
    localparam int DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ie_w_en,
    input  logic               ie_w_data,
    input  logic               mask_w_en,
    input  logic [NUM_IRQ-1:0] mask_w_data,
    input  logic               int_ack,
    input  logic [31:0]        ack_pc,
    input  logic               eret,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [31:0]        epc,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_full
);

    logic [NUM_IRQ-1:0] irq_cap;
    logic [NUM_IRQ-1:0] irq_prev_reg;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] in_service_reg;
    logic [NUM_IRQ-1:0] in_service_next;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] win_onehot;
    logic [NUM_IRQ-1:0] cur_onehot;
    logic               ie_reg;
    logic [DEPTH_W-1:0] depth_reg;
    logic [DEPTH_W-1:0] depth_next;
    logic [DEPTH_W-1:0] wr_idx;
    logic [31:0]        stack_reg [NEST_DEPTH];
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    cur_id;
    logic               full;
    logic               ack_fire;
    logic               eret_fire;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_reg;
    logic [NUM_IRQ-1:0] sync2_reg;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_cap = sync2_reg;
`else
    assign irq_cap = irq_in;
`endif

    assign irq_edge = irq_cap & ~irq_prev_reg;

    // Ids are index+1 so that 0 can stand for "no channel" on both sides of the compare.
    always_comb begin
        win_id = '0;
        cur_id = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending_reg[i] && mask_reg[i]) win_id = ID_W'(i + 1);
            if (in_service_reg[i])             cur_id = ID_W'(i + 1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_id == ID_W'(gi + 1));
            assign cur_onehot[gi] = (cur_id == ID_W'(gi + 1));
        end
    endgenerate

    assign full    = (depth_reg == DEPTH_W'(NEST_DEPTH));
    assign int_req = ie_reg && (win_id != '0) && (win_id > cur_id) && !full;
    assign int_id  = int_req ? win_id : '0;

    assign ack_fire  = en && int_ack && int_req;
    assign eret_fire = en && eret && (depth_reg != '0);

    // A fresh edge is OR-ed in after the ack clear, so a same-cycle edge keeps the bit set.
    assign pending_next    = (pending_reg & ~(win_onehot & {NUM_IRQ{ack_fire}})) | irq_edge;
    assign in_service_next = (in_service_reg & ~(cur_onehot & {NUM_IRQ{eret_fire}}))
                           | (win_onehot & {NUM_IRQ{ack_fire}});

    always_comb begin
        depth_next = depth_reg;
        case ({ack_fire, eret_fire})
            2'b10:   depth_next = depth_reg + 1'b1;
            2'b01:   depth_next = depth_reg - 1'b1;
            default: depth_next = depth_reg;
        endcase
    end

    // Simultaneous eret+ack overwrites the current top instead of pushing.
    assign wr_idx = eret_fire ? (depth_reg - 1'b1) : depth_reg;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_reg   <= '0;
            pending_reg    <= '0;
            in_service_reg <= '0;
            mask_reg       <= '0;
            ie_reg         <= 1'b0;
            depth_reg      <= '0;
        end else begin
            irq_prev_reg   <= irq_cap;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            depth_reg      <= depth_next;
            if (en && mask_w_en) mask_reg <= mask_w_data;
            if (en && ie_w_en)   ie_reg   <= ie_w_data;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEST_DEPTH; i++) stack_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (ack_fire && (wr_idx == DEPTH_W'(i))) stack_reg[i] <= ack_pc;
            end
        end
    end

    always_comb begin
        epc = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth_reg == DEPTH_W'(i + 1)) epc = stack_reg[i];
        end
    end

    assign pending    = pending_reg;
    assign in_service = in_service_reg;
    assign depth      = depth_reg;
    assign stack_full = full;

endmodule

// File: tb/tb_nested_int_controller.sv
// Self-checking bench for nested_int_controller: directed scenarios pinned with literals,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_nested_int_controller;

    localparam int NUM_IRQ    = 8;
    localparam int NEST_DEPTH = 4;
    localparam int ID_W       = $clog2(NUM_IRQ + 1);
    localparam int DEPTH_W    = $clog2(NEST_DEPTH + 1);
`ifdef IRQ_SYNC_EN
    localparam int CAP_LAT = 3;
`else
    localparam int CAP_LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [NUM_IRQ-1:0] irq_in;
    logic               ie_w_en;
    logic               ie_w_data;
    logic               mask_w_en;
    logic [NUM_IRQ-1:0] mask_w_data;
    logic               int_ack;
    logic [31:0]        ack_pc;
    logic               eret;
    logic               int_req;
    logic [ID_W-1:0]    int_id;
    logic [31:0]        epc;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] in_service;
    logic [DEPTH_W-1:0] depth;
    logic               stack_full;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NUM_IRQ-1:0] m_pend, m_is, m_mask, m_prev, m_s1, m_s2;
    logic               m_ie;
    logic [31:0]        m_stk [$];

    nested_int_controller #(.NUM_IRQ(NUM_IRQ), .NEST_DEPTH(NEST_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .irq_in(irq_in),
        .ie_w_en(ie_w_en), .ie_w_data(ie_w_data),
        .mask_w_en(mask_w_en), .mask_w_data(mask_w_data),
        .int_ack(int_ack), .ack_pc(ack_pc), .eret(eret),
        .int_req(int_req), .int_id(int_id), .epc(epc),
        .pending(pending), .in_service(in_service),
        .depth(depth), .stack_full(stack_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int m_win();
        int w = -1;
        for (int i = 0; i < NUM_IRQ; i++) if (m_pend[i] && m_mask[i]) w = i;
        return w;
    endfunction

    function automatic int m_cur();
        int c = -1;
        for (int i = 0; i < NUM_IRQ; i++) if (m_is[i]) c = i;
        return c;
    endfunction

    function automatic bit m_req();
        int w = m_win();
        return m_ie && (w >= 0) && (w > m_cur()) && (m_stk.size() < NEST_DEPTH);
    endfunction

    task automatic model_reset();
        m_pend = '0; m_is = '0; m_mask = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_ie = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_update();
        int w, c;
        bit do_ack, do_eret;
        logic [NUM_IRQ-1:0] cap;
        w = m_win();
        c = m_cur();
        do_ack  = en && int_ack && m_req();
        do_eret = en && eret && (m_stk.size() > 0);
        if (do_eret) begin
            m_is[c] = 1'b0;
            void'(m_stk.pop_back());
        end
        if (do_ack) begin
            m_pend[w] = 1'b0;
            m_is[w]   = 1'b1;
            m_stk.push_back(ack_pc);
        end
`ifdef IRQ_SYNC_EN
        cap  = m_s2;
        m_s2 = m_s1;
        m_s1 = irq_in;
`else
        cap = irq_in;
`endif
        for (int i = 0; i < NUM_IRQ; i++) if (cap[i] && !m_prev[i]) m_pend[i] = 1'b1;
        m_prev = cap;
        if (en && ie_w_en)   m_ie   = ie_w_data;
        if (en && mask_w_en) m_mask = mask_w_data;
        if (do_ack || do_eret)
            $display("txn t=%0t ack=%0d eret=%0d ch=%0d pc=0x%0h depth=%0d",
                     $time, do_ack, do_eret, do_ack ? w : c, ack_pc, m_stk.size());
    endtask

    task automatic check_all();
        int w;
        bit r;
        w = m_win();
        r = m_req();
        cmp("int_req", 32'(int_req), 32'(r));
        cmp("int_id", 32'(int_id), r ? 32'(w + 1) : 32'd0);
        cmp("epc", epc, (m_stk.size() > 0) ? m_stk[$] : 32'd0);
        cmp("pending", 32'(pending), 32'(m_pend));
        cmp("in_service", 32'(in_service), 32'(m_is));
        cmp("depth", 32'(depth), 32'(m_stk.size()));
        cmp("stack_full", 32'(stack_full), 32'(m_stk.size() == NEST_DEPTH));
    endtask

    // Inputs are driven just after posedge; DUT and model both update at the falling edge.
    task automatic step();
        @(negedge clk);
        model_update();
        @(posedge clk);
        #1;
        check_all();
        int_ack   = 1'b0;
        eret      = 1'b0;
        ie_w_en   = 1'b0;
        mask_w_en = 1'b0;
    endtask

    task automatic pulse(input int ch);
        irq_in[ch] = 1'b1;
        step();
        irq_in[ch] = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic ack(input logic [31:0] pc);
        int_ack = 1'b1;
        ack_pc  = pc;
        step();
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; irq_in = '0;
        ie_w_en = 1'b0; ie_w_data = 1'b0; mask_w_en = 1'b0; mask_w_data = '0;
        int_ack = 1'b0; ack_pc = '0; eret = 1'b0;
        model_reset();
        #12;
        cmp("rst_int_req", 32'(int_req), 0);
        cmp("rst_int_id", 32'(int_id), 0);
        cmp("rst_epc", epc, 0);
        cmp("rst_pending", 32'(pending), 0);
        cmp("rst_depth", 32'(depth), 0);
        cmp("rst_full", 32'(stack_full), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single interrupt
        ie_w_en = 1'b1; ie_w_data = 1'b1; mask_w_en = 1'b1; mask_w_data = 8'hFF;
        step();
        pulse(2);
        cmp("t1_pending", 32'(pending), 32'h04);
        cmp("t1_req", 32'(int_req), 1);
        cmp("t1_id", 32'(int_id), 3);
        cmp("t1_model_id", m_req() ? 32'(m_win() + 1) : 32'd0, 3);
        ack(32'h100);
        cmp("t1_in_service", 32'(in_service), 32'h04);
        cmp("t1_depth", 32'(depth), 1);
        cmp("t1_epc", epc, 32'h100);
        cmp("t1_req_after", 32'(int_req), 0);

        // 2: nesting and lower-priority blocking
        pulse(5);
        cmp("t2_id", 32'(int_id), 6);
        ack(32'h200);
        cmp("t2_depth", 32'(depth), 2);
        cmp("t2_epc", epc, 32'h200);
        pulse(1);
        cmp("t2_low_req", 32'(int_req), 0);
        do_eret();
        cmp("t2_epc_pop", epc, 32'h100);
        cmp("t2_in_service", 32'(in_service), 32'h04);
        cmp("t2_model_epc", m_stk[$], 32'h100);
        do_eret();
        cmp("t2_id_ch1", 32'(int_id), 2);

        // 3: fill the stack
        ack(32'h110);
        pulse(3); ack(32'h130);
        pulse(5); ack(32'h150);
        pulse(7); ack(32'h170);
        cmp("t3_full", 32'(stack_full), 1);
        cmp("t3_is", 32'(in_service), 32'hAA);
        pulse(7);
        cmp("t3_pending", 32'(pending), 32'h80);
        cmp("t3_req_full", 32'(int_req), 0);
        do_eret();
        cmp("t3_full_after", 32'(stack_full), 0);
        cmp("t3_req_after", 32'(int_req), 1);
        cmp("t3_id_after", 32'(int_id), 8);
        ack(32'h171);
        for (int k = 0; k < 4; k++) do_eret();
        cmp("t3_drained", 32'(depth), 0);

        // 4: mask and global enable
        mask_w_en = 1'b1; mask_w_data = 8'h00;
        step();
        pulse(4);
        cmp("t4_pending", 32'(pending), 32'h10);
        cmp("t4_req_masked", 32'(int_req), 0);
        mask_w_en = 1'b1; mask_w_data = 8'h10;
        step();
        cmp("t4_req_unmasked", 32'(int_req), 1);
        ie_w_en = 1'b1; ie_w_data = 1'b0;
        step();
        cmp("t4_req_ie0", 32'(int_req), 0);
        cmp("t4_pending_kept", 32'(pending), 32'h10);
        ie_w_en = 1'b1; ie_w_data = 1'b1;
        step();
        cmp("t4_id_ie1", 32'(int_id), 5);
        mask_w_en = 1'b1; mask_w_data = 8'hFF;
        step();

        // 5: same-cycle eret+ack, ignored strobes, en gating
        ack(32'h400);
        pulse(6); ack(32'h500);
        pulse(7);
        eret = 1'b1; int_ack = 1'b1; ack_pc = 32'h300;
        step();
        cmp("t5_depth", 32'(depth), 2);
        cmp("t5_epc", epc, 32'h300);
        cmp("t5_is", 32'(in_service), 32'h90);
        do_eret(); do_eret();
        do_eret();
        cmp("t5_eret_empty_depth", 32'(depth), 0);
        cmp("t5_eret_empty_is", 32'(in_service), 0);
        ack(32'h999);
        cmp("t5_ack_noreq_depth", 32'(depth), 0);
        pulse(3);
        cmp("t5_req_ch3", 32'(int_id), 4);
        en = 1'b0; int_ack = 1'b1; ack_pc = 32'h777; irq_in[0] = 1'b1;
        step();
        en = 1'b1; irq_in[0] = 1'b0;
        step(); step(); step();
        cmp("t5_en0_depth", 32'(depth), 0);
        cmp("t5_en0_pending", 32'(pending), 32'h09);

        // 6: async reset mid-handler, then capture latency
        ack(32'hA00);
        pulse(5); ack(32'hA01);
        pulse(6); ack(32'hA02);
        cmp("t6_depth", 32'(depth), 3);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("t6_rst_req", 32'(int_req), 0);
        cmp("t6_rst_id", 32'(int_id), 0);
        cmp("t6_rst_epc", epc, 0);
        cmp("t6_rst_pending", 32'(pending), 0);
        cmp("t6_rst_is", 32'(in_service), 0);
        cmp("t6_rst_depth", 32'(depth), 0);
        cmp("t6_rst_full", 32'(stack_full), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        irq_in[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            cmp("lat_pending0", 32'(pending[0]), 32'(k >= CAP_LAT));
        end
        irq_in[0] = 1'b0;

        // Randomized traffic
        ie_w_en = 1'b1; ie_w_data = 1'b1; mask_w_en = 1'b1; mask_w_data = 8'hFF;
        step();
        for (int n = 0; n < 1500; n++) begin
            irq_in    = NUM_IRQ'($urandom & $urandom);
            en        = ($urandom_range(0, 9) != 0);
            int_ack   = ($urandom_range(0, 2) == 0);
            ack_pc    = $urandom;
            eret      = ($urandom_range(0, 4) == 0);
            mask_w_en = ($urandom_range(0, 39) == 0);
            mask_w_data = NUM_IRQ'($urandom | $urandom);
            ie_w_en   = ($urandom_range(0, 49) == 0);
            ie_w_data = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
